// File: rtl/audio_tone_mixer.sv
// audio_tone_mixer: multi-channel DDS tone mixer driving a 1-bit audio DAC.
// Define AUDIO_SIGMA_DELTA_EN to swap the PWM comparator for a sigma-delta.
module audio_tone_mixer #(
    parameter int NUM_CH   = 4,
    parameter int PHASE_W  = 20,
    parameter int TABLE_AW = 4,
    parameter int VOL_W    = 4,
    parameter int PWM_W    = 8,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               CLK12,
    input  logic               RST,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic [VOL_W-1:0]   cfg_vol,
    input  logic               cfg_en,
    output logic [PWM_W-1:0]   mix_out,
    output logic               sample_strobe,
    output logic               AUDIO_PWM
);

    localparam int TAB_N  = 1 << TABLE_AW;
    localparam int PROD_W = 8 + VOL_W + 1;
    localparam int SUM_W  = 8 + CH_W + 1;

    localparam logic [PWM_W-1:0] CNT_MAX = '1;
    localparam logic [PWM_W-1:0] MID     = {1'b1, {(PWM_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        LATCH
    } state_t;

    // Truncation toward zero reproduces the reference table; the tiny
    // bias keeps exact peaks (127) from rounding down on float error.
    function automatic logic signed [7:0] sine_at(input int k);
        real a;
        real v;
        int  r;
        a = 2.0 * 3.141592653589793 * k / TAB_N;
        v = 127.0 * $sin(a);
        if (v >= 0.0) r = $rtoi(v + 1.0e-6);
        else          r = $rtoi(v - 1.0e-6);
        return 8'(r);
    endfunction

    logic signed [7:0] sin_tab [TAB_N];

    for (genvar k = 0; k < TAB_N; k++) begin : g_tab
        localparam logic signed [7:0] V = sine_at(k);
        assign sin_tab[k] = V;
    end

    state_t            state;
    logic [CH_W-1:0]   ch;
    logic signed [SUM_W-1:0] sum;

    logic [PHASE_W-1:0] phase [NUM_CH];
    logic [PHASE_W-1:0] inc   [NUM_CH];
    logic [VOL_W-1:0]   vol   [NUM_CH];
    logic [NUM_CH-1:0]  en;

    logic [PWM_W-1:0] count;
    logic [PWM_W-1:0] duty;

    logic [PHASE_W-1:0]       ph_next;
    logic [TABLE_AW-1:0]      idx;
    logic signed [7:0]        samp;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  term;
    logic signed [7:0]        m;
    logic [7:0]               mb;
    logic [PWM_W-1:0]         mix_next;
    logic                     cfg_hit;
    logic                     wrap;

    assign wrap    = (count == CNT_MAX);
    assign cfg_hit = cfg_we && (int'(cfg_ch) < NUM_CH);

    // Per-channel term for the channel currently being accumulated.
    always_comb begin
        ph_next  = phase[ch] + inc[ch];
        idx      = ph_next[PHASE_W-1 -: TABLE_AW];
        samp     = sin_tab[idx];
        prod     = PROD_W'(samp) * PROD_W'($signed({1'b0, vol[ch]}));
        term     = en[ch] ? SUM_W'(prod >>> VOL_W) : '0;
        m        = 8'(sum >>> CH_W);
        mb       = {~m[7], m[6:0]};
        mix_next = PWM_W'(mb) << (PWM_W - 8);
    end

    // Frame sequencer: accumulate one channel per cycle, then latch the mix.
    always_ff @(posedge CLK12 or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            ch            <= '0;
            sum           <= '0;
            mix_out       <= MID;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (wrap) begin
                        state <= ACCUM;
                        ch    <= '0;
                        sum   <= '0;
                    end
                end
                ACCUM: begin
                    sum <= sum + term;
                    if (int'(ch) == NUM_CH - 1) state <= LATCH;
                    else ch <= ch + CH_W'(1);
                end
                LATCH: begin
                    mix_out       <= mix_next;
                    sample_strobe <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Channel registers; a config write overrides the accumulator update.
    always_ff @(posedge CLK12 or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
                vol[i]   <= '0;
            end
            en <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (state == ACCUM && int'(ch) == i && en[i])
                    phase[i] <= ph_next;
                if (cfg_hit && int'(cfg_ch) == i) begin
                    inc[i] <= cfg_inc;
                    vol[i] <= cfg_vol;
                    en[i]  <= cfg_en;
                    if (!cfg_en) phase[i] <= '0;
                end
            end
        end
    end

`ifdef AUDIO_SIGMA_DELTA_EN
    logic [PWM_W:0] acc;

    // First-order sigma-delta: carry out of the accumulator is the bit stream.
    always_ff @(posedge CLK12 or posedge RST) begin
        if (RST) begin
            count     <= '0;
            duty      <= MID;
            acc       <= '0;
            AUDIO_PWM <= 1'b0;
        end else begin
            count     <= count + PWM_W'(1);
            if (wrap) duty <= mix_out;
            acc       <= {1'b0, acc[PWM_W-1:0]} + {1'b0, duty};
            AUDIO_PWM <= acc[PWM_W];
        end
    end
`else
    // PWM comparator; duty only reloads at wrap so periods never glitch.
    always_ff @(posedge CLK12 or posedge RST) begin
        if (RST) begin
            count     <= '0;
            duty      <= MID;
            AUDIO_PWM <= 1'b0;
        end else begin
            count     <= count + PWM_W'(1);
            if (wrap) duty <= mix_out;
            AUDIO_PWM <= (count < duty);
        end
    end
`endif

endmodule

// File: tb/tb_audio_tone_mixer.sv
// tb_audio_tone_mixer: directed checks of the tone mixer, default PWM build.
// Expected mixes are hand-derived from the 16-entry sine table.
module tb_audio_tone_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [19:0] cfg_inc;
    logic [3:0]  cfg_vol;
    logic        cfg_en;
    logic [7:0]  mix_out;
    logic        sample_strobe;
    logic        audio_pwm;

    int n_run  = 0;
    int n_fail = 0;

    // ch0 inc=0x10000 vol=15: table index 1..15,0,1
    int seq [17] = '{139, 148, 155, 157, 155, 148, 139, 128,
                     116, 107, 100, 98, 100, 107, 116, 128, 139};

    audio_tone_mixer dut (
        .CLK12         (clk),
        .RST           (rst),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_inc       (cfg_inc),
        .cfg_vol       (cfg_vol),
        .cfg_en        (cfg_en),
        .mix_out       (mix_out),
        .sample_strobe (sample_strobe),
        .AUDIO_PWM     (audio_pwm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!sample_strobe && cyc < 600);
        if (!sample_strobe) chk("strobe_timeout", 0, 1);
    endtask

    task automatic cfg_write(input int ch, input int inc,
                             input int vol, input int en);
        cfg_ch  = 2'(ch);
        cfg_inc = 20'(inc);
        cfg_vol = 4'(vol);
        cfg_en  = en[0];
        cfg_we  = 1'b1;
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    task automatic count_high(output int h);
        h = 0;
        repeat (256) begin
            @(negedge clk);
            h += int'(audio_pwm);
        end
    endtask

    initial begin
        int c;
        int h;
        int s;
        rst     = 1'b1;
        cfg_we  = 1'b0;
        cfg_ch  = '0;
        cfg_inc = '0;
        cfg_vol = '0;
        cfg_en  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mix", int'(mix_out), 128);
        chk("rst_strobe", int'(sample_strobe), 0);
        chk("rst_pwm", int'(audio_pwm), 0);
        rst = 1'b0;

        // idle: strobe width/period, mid-scale mix, 50% duty
        wait_strobe(c);
        chk("idle_mix", int'(mix_out), 128);
        @(negedge clk);
        chk("strobe_width", int'(sample_strobe), 0);
        wait_strobe(c);
        chk("strobe_period", c + 1, 256);
        repeat (251) @(negedge clk);
        count_high(h);
        chk("pwm_high_idle", h, 128);

        // single channel tone sequence
        wait_strobe(c);
        cfg_write(0, 'h10000, 15, 1);
        for (int f = 0; f < 17; f++) begin
            wait_strobe(c);
            chk($sformatf("seq%0d", f), int'(mix_out), seq[f]);
        end

        // disable ch0 while it is being accumulated (count 0)
        repeat (251) @(negedge clk);
        cfg_write(0, 'h10000, 15, 0);
        wait_strobe(c);
        chk("dis_frame_mix", int'(mix_out), 148);
        chk("dis_phase", int'(dut.phase[0]), 0);
        chk("dis_en", int'(dut.en), 0);
        wait_strobe(c);
        chk("dis_next_mix", int'(mix_out), 128);
        cfg_write(0, 'h10000, 15, 1);
        wait_strobe(c);
        chk("reen_mix", int'(mix_out), 139);

        // all four channels at table index 4
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cfg_write(i, 'h40000, 15, 1);
        wait_strobe(c);
        chk("all4_mix", int'(mix_out), 247);
        repeat (251) @(negedge clk);
        count_high(h);
        chk("pwm_high_247", h, 247);

        // reset mid-ACCUM (count 1, channel 1)
        wait_strobe(c);
        repeat (252) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_pwm", int'(audio_pwm), 0);
        chk("arst_mix", int'(mix_out), 128);
        chk("arst_strobe", int'(sample_strobe), 0);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_inc0", int'(dut.inc[0]), 0);
        chk("arst_en", int'(dut.en), 0);
        s = 0;
        repeat (255) begin
            @(negedge clk);
            s += int'(sample_strobe);
        end
        chk("arst_no_strobe", s, 0);
        wait_strobe(c);
        chk("arst_strobe_at", c, 6);
        chk("arst_next_mix", int'(mix_out), 128);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
